dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU port) and a DMA/loader port (valid/ready).
- Sits between the MEM stage, the DMA engine and the data memory.
- Data memory reads combinationally and commits writes on the falling clock edge, so every granted access completes in the cycle it is granted.
- CPU has priority; an anti-starvation counter forces a DMA slot and stalls the CPU for one cycle.

Parameters:
- MAX_WAIT, 4, cycles a pending DMA request may be refused before it is forced through (1..15).
- ADDR_LIMIT_BITS, 13, byte-address bits the memory decodes (2048 words); higher set bits on a DMA address raise an error.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- cpu_req  in  1  MEM stage wants an access this cycle
- cpu_we  in  1  CPU access is a store
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  load data (mem_rdata passthrough)
- cpu_stall  out  1  freeze pipeline; CPU access not performed this cycle
- dma_valid  in  1  DMA request pending
- dma_we  in  1  DMA access is a write
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_ready  out  1  DMA access performed this cycle
- dma_rdata  out  32  DMA read data, valid when dma_ready=1
- dma_err  out  1  registered one-cycle pulse: previous DMA access was out of range
- mem_addr  out  32  to data memory address
- mem_wdata  out  32  to data memory write data
- mem_we  out  1  to data memory write enable
- mem_rdata  in  32  from data memory read data

Behaviour:
- Clock is `clock`. Reset is `reset_n`: one clock, synchronous, active-low.
- Reset: wait_cnt=0, dma_err=0, stats=0. While reset_n=0: mem_we=0, dma_ready=0, cpu_stall=0.
- Force condition: force = dma_valid && (wait_cnt == MAX_WAIT).
- Grant is combinational each cycle, in this priority:
  - force: grant DMA; cpu_stall = cpu_req.
  - else cpu_req: grant CPU; cpu_stall=0.
  - else dma_valid: grant DMA.
  - else: no grant; mem_we=0.
- Muxing:
  - mem_addr/mem_wdata come from the granted port; with no grant they come from the CPU port.
  - mem_we = granted port's we, gated as described here.
  - dma_ready = DMA granted.
  - cpu_rdata = dma_rdata = mem_rdata.
- wait_cnt, at the rising edge:
  - cleared if dma_valid=0 or DMA granted;
  - else incremented, saturating at MAX_WAIT.
- Forced slot: exactly one cycle. After it wait_cnt=0, so the CPU then wins for at least MAX_WAIT cycles.
- Out of range: dma_addr[31:ADDR_LIMIT_BITS] != 0 when the DMA is granted.
  - dma_ready=1 (the access is consumed) and mem_we=0 (no write).
  - dma_err=1 on the next cycle for one cycle.
  - CPU addresses are never range-checked.
- No cpu_req and no dma_valid: no state change except wait_cnt clear.
- Simultaneous cpu_req and dma_valid with wait_cnt<MAX_WAIT: CPU served, wait_cnt+1.
- Reset asserted mid-stall: stall drops in that same cycle and the counter clears. The DMA must re-present its request after reset.
- All outputs other than dma_err and the stats counters are combinational from inputs plus wait_cnt.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, three 16-bit wrapping counters are added, all cleared by reset:
  - stat_cpu (CPU grants)
  - stat_dma (DMA grants, including errored accesses)
  - stat_stall (cycles with cpu_stall=1)
- Exposed as extra output ports stat_cpu, stat_dma, stat_stall (16 bits each).
- When undefined, these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: reset_n=0 for 2 cycles while cpu_req=1, dma_valid=1 -> mem_we=0, dma_ready=0, cpu_stall=0, dma_err=0; after release, stats read 0.
- CPU only: store 0xDEADBEEF to 0x40, then load 0x40 -> mem_we=1 in the store cycle, cpu_rdata=0xDEADBEEF, cpu_stall never 1.
- Idle CPU: dma_valid=1, we=1, addr 0x80, data 0x12345678 -> dma_ready=1 in the same cycle; later CPU load of 0x80 returns 0x12345678.
- Contention: cpu_req=1 and dma_valid=1 continuously, MAX_WAIT=4 -> CPU served 4 cycles, 5th cycle dma_ready=1 and cpu_stall=1, pattern repeats with period 5.
- Range error: DMA write to 0x0000_2000 -> dma_ready=1, mem_we=0, dma_err=1 next cycle only; memory word 0 unchanged.
- Stats (DMEM_ARB_STATS_EN): after the contention test runs 10 cycles -> stat_cpu=8, stat_dma=2, stat_stall=2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter for the single-port data memory
//
// CPU (MEM stage) has priority. A DMA request refused MAX_WAIT times in a row
// is forced through for one cycle, stalling the CPU for that cycle.
// The memory reads combinationally and writes on the falling edge, so every
// granted access completes in the cycle it is granted.
//
// Optional feature macro: DMEM_ARB_STATS_EN (adds stat_cpu/stat_dma/stat_stall).
//
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   cpu_req/we/addr/wdata   CPU access request
//   cpu_rdata, cpu_stall    CPU load data, pipeline freeze
//   dma_valid/we/addr/wdata DMA access request
//   dma_ready, dma_rdata    DMA access performed this cycle, read data
//   dma_err                 one-cycle pulse: previous DMA access out of range
//   mem_addr/wdata/we       to data memory
//   mem_rdata               from data memory
//   stat_cpu/dma/stall      grant and stall counters (DMEM_ARB_STATS_EN only)
module dmem_arbiter #(
  parameter int MAX_WAIT        = 4,
  parameter int ADDR_LIMIT_BITS = 13
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_valid,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ready,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_cpu,
  output logic [15:0] stat_dma,
  output logic [15:0] stat_stall
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       force_dma;
  logic       grant_dma;
  logic       grant_cpu;
  logic       dma_oor;

  always_comb begin
    force_dma = dma_valid && (wait_cnt == WAIT_MAX);
    // Grants are suppressed while reset is held so nothing reaches memory.
    grant_dma = reset_n && (force_dma || (dma_valid && !cpu_req));
    grant_cpu = reset_n && cpu_req && !force_dma;
    dma_oor   = (dma_addr >> ADDR_LIMIT_BITS) != 32'd0;

    cpu_stall = reset_n && force_dma && cpu_req;
    dma_ready = grant_dma;

    // With no grant the CPU port drives the memory address/data.
    mem_addr  = grant_dma ? dma_addr  : cpu_addr;
    mem_wdata = grant_dma ? dma_wdata : cpu_wdata;
    // An out-of-range DMA access is consumed but must never write.
    mem_we    = grant_dma ? (dma_we && !dma_oor) : (grant_cpu && cpu_we);

    cpu_rdata = mem_rdata;
    dma_rdata = mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
      dma_err  <= 1'b0;
    end else begin
      dma_err <= grant_dma && dma_oor;
      if (!dma_valid || grant_dma) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_cpu   <= 16'd0;
      stat_dma   <= 16'd0;
      stat_stall <= 16'd0;
    end else begin
      if (grant_cpu) stat_cpu   <= stat_cpu + 16'd1;
      if (grant_dma) stat_dma   <= stat_dma + 16'd1;
      if (cpu_stall) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_valid, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ready, dma_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_cpu, stat_dma, stat_stall;
`endif

  dmem_arbiter #(.MAX_WAIT(4), .ADDR_LIMIT_BITS(13)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_cpu(stat_cpu), .stat_dma(stat_dma), .stat_stall(stat_stall)
`endif
  );

  // Data memory model: combinational read, write on the falling edge.
  logic [31:0] mem [0:2047];
  assign mem_rdata = mem[mem_addr[12:2]];
  always @(negedge clock) begin
    if (mem_we) mem[mem_addr[12:2]] <= mem_wdata;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    bit          rst_n;
    bit          creq, cwe;
    bit [31:0]   caddr, cwd;
    bit          dv, dwe;
    bit [31:0]   daddr, dwd;
    bit          e_we, e_stall, e_ready, e_err;
    bit          chk_addr;
    bit [31:0]   e_addr;
    bit          chk_rd;
    bit [31:0]   e_rd;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input bit rst, input bit creq, input bit cwe, input bit [31:0] caddr,
                     input bit [31:0] cwd, input bit dv, input bit dwe, input bit [31:0] daddr,
                     input bit [31:0] dwd, input bit e_we, input bit e_stall, input bit e_ready,
                     input bit e_err, input bit chk_addr, input bit [31:0] e_addr,
                     input bit chk_rd, input bit [31:0] e_rd);
    vec_t v;
    v.id = vecs.size(); v.rst_n = rst;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dv = dv; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.e_we = e_we; v.e_stall = e_stall; v.e_ready = e_ready; v.e_err = e_err;
    v.chk_addr = chk_addr; v.e_addr = e_addr; v.chk_rd = chk_rd; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  // Contention row: CPU stores 0x11111111 to 0x44, DMA reads 0x80.
  task automatic add_cont(input bit forced);
    if (forced) add(1, 1,1,32'h44,32'h11111111, 1,0,32'h80,32'h0, 0,1,1,0, 1,32'h80, 1,32'h12345678);
    else        add(1, 1,1,32'h44,32'h11111111, 1,0,32'h80,32'h0, 1,0,0,0, 1,32'h44, 0,32'h0);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, e;
    int   cont_start;
`ifdef DMEM_ARB_STATS_EN
    int m_cpu = 0, m_dma = 0, m_stall = 0;
    int s_cpu = 0, s_dma = 0, s_stall = 0;
`endif

    for (int k = 0; k < 2048; k++) mem[k] = 32'h0;

    // Reset held for two cycles with both requesters active.
    add(0, 1,1,32'h40,32'h0, 1,1,32'h0,32'hBAD, 0,0,0,0, 0,32'h0, 0,32'h0);
    add(0, 1,1,32'h40,32'h0, 1,1,32'h0,32'hBAD, 0,0,0,0, 0,32'h0, 0,32'h0);
    // Idle: memory address follows the CPU port.
    add(1, 0,0,32'h3C,32'h0, 0,0,32'h99C,32'h0, 0,0,0,0, 1,32'h3C, 0,32'h0);
    // CPU store / load.
    add(1, 1,1,32'h40,32'hDEADBEEF, 0,0,32'h0,32'h0, 1,0,0,0, 1,32'h40, 0,32'h0);
    add(1, 1,0,32'h40,32'h0, 0,0,32'h0,32'h0, 0,0,0,0, 1,32'h40, 1,32'hDEADBEEF);
    // DMA write with idle CPU, then CPU reads it back.
    add(1, 0,0,32'h0,32'h0, 1,1,32'h80,32'h12345678, 1,0,1,0, 1,32'h80, 0,32'h0);
    add(1, 1,0,32'h80,32'h0, 0,0,32'h0,32'h0, 0,0,0,0, 1,32'h80, 1,32'h12345678);
    // Seed word 0, DMA read of 0x40.
    add(1, 1,1,32'h0,32'hA5A5A5A5, 0,0,32'h0,32'h0, 1,0,0,0, 1,32'h0, 0,32'h0);
    add(1, 0,0,32'h0,32'h0, 1,0,32'h40,32'h0, 0,0,1,0, 1,32'h40, 1,32'hDEADBEEF);
    // Out-of-range DMA write: consumed, no write, error pulse next cycle only.
    add(1, 0,0,32'h0,32'h0, 1,1,32'h2000,32'hFFFFFFFF, 0,0,1,0, 1,32'h2000, 0,32'h0);
    add(1, 1,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0,1, 1,32'h0, 1,32'hA5A5A5A5);
    add(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0,0, 0,32'h0, 0,32'h0);
    // Contention: period 5, forced DMA slot in the 5th cycle.
    cont_start = vecs.size();
    for (int k = 0; k < 10; k++) add_cont((k % 5) == 4);
    // DMA dropping its request clears the wait counter.
    add_cont(0); add_cont(0);
    add(1, 1,0,32'h40,32'h0, 0,0,32'h80,32'h0, 0,0,0,0, 1,32'h40, 1,32'hDEADBEEF);
    for (int k = 0; k < 5; k++) add_cont(k == 4);
    // Reset while the force would fire: stall drops, counter clears.
    for (int k = 0; k < 4; k++) add_cont(0);
    add(0, 1,1,32'h44,32'h11111111, 1,0,32'h80,32'h0, 0,0,0,0, 0,32'h0, 0,32'h0);
    add_cont(0);
    add(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0, 0,0,0,0, 0,32'h0, 0,32'h0);

    // Untracked initial reset so registered outputs start defined.
    reset_n = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_valid = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    @(posedge clock); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      reset_n = v.rst_n; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr;
      cpu_wdata = v.cwd; dma_valid = v.dv; dma_we = v.dwe; dma_addr = v.daddr;
      dma_wdata = v.dwd;
      exp_q.push_back(v);
      #3;
      e = exp_q.pop_front();
      chk1($sformatf("v%0d.mem_we", e.id), mem_we, e.e_we);
      chk1($sformatf("v%0d.cpu_stall", e.id), cpu_stall, e.e_stall);
      chk1($sformatf("v%0d.dma_ready", e.id), dma_ready, e.e_ready);
      chk1($sformatf("v%0d.dma_err", e.id), dma_err, e.e_err);
      if (e.chk_addr) chk32($sformatf("v%0d.mem_addr", e.id), mem_addr, e.e_addr);
      if (e.chk_rd) begin
        chk32($sformatf("v%0d.cpu_rdata", e.id), cpu_rdata, e.e_rd);
        chk32($sformatf("v%0d.dma_rdata", e.id), dma_rdata, e.e_rd);
      end
`ifdef DMEM_ARB_STATS_EN
      chk32($sformatf("v%0d.stat_cpu", e.id), {16'h0, stat_cpu}, m_cpu);
      chk32($sformatf("v%0d.stat_dma", e.id), {16'h0, stat_dma}, m_dma);
      chk32($sformatf("v%0d.stat_stall", e.id), {16'h0, stat_stall}, m_stall);
      if (i == cont_start) begin
        s_cpu = stat_cpu; s_dma = stat_dma; s_stall = stat_stall;
      end
      if (i == cont_start + 10) begin
        chk32("contention.stat_cpu_delta", stat_cpu - s_cpu, 32'd8);
        chk32("contention.stat_dma_delta", stat_dma - s_dma, 32'd2);
        chk32("contention.stat_stall_delta", stat_stall - s_stall, 32'd2);
      end
      if (!e.rst_n) begin
        m_cpu = 0; m_dma = 0; m_stall = 0;
      end else begin
        m_cpu   += (e.creq && !e.e_stall) ? 1 : 0;
        m_dma   += e.e_ready ? 1 : 0;
        m_stall += e.e_stall ? 1 : 0;
      end
`endif
      @(posedge clock); #1;
    end

    chk32("mem_word0_after_oor", mem[0], 32'hA5A5A5A5);
    chk32("mem_word_0x44", mem[17], 32'h11111111);
    chk32("mem_word_0x80", mem[32], 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
